// File: rtl/nonrestoring_divider.sv
// Iterative unsigned non-restoring divider: one add/subtract step per clock on a
// single BUS_WIDTH+1 bit adder, with a final remainder-correction step.
module nonrestoring_divider #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] dividend,
  input  logic [BUS_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] quotient,
  output logic [BUS_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = $clog2(BUS_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BUS_WIDTH-1:0] d_q, d_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH:0]   r_q, r_d;
  logic [BUS_WIDTH-1:0] q_q, q_d;
  logic [BUS_WIDTH-1:0] quotient_q, quotient_d;
  logic [BUS_WIDTH-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  // Shared adder: RUN feeds the shifted partial remainder, FIX feeds R itself.
  logic                 add_sub;
  logic [BUS_WIDTH:0]   adder_a, adder_b, carry_in, adder_sum;

  always_comb begin
    add_sub   = (state_q == FIX) ? 1'b0 : ~r_q[BUS_WIDTH];
    adder_a   = (state_q == FIX) ? r_q : {r_q[BUS_WIDTH-1:0], a_q[BUS_WIDTH-1]};
    adder_b   = {1'b0, d_q} ^ {(BUS_WIDTH+1){add_sub}};
    carry_in  = {{BUS_WIDTH{1'b0}}, add_sub};
    adder_sum = adder_a + adder_b + carry_in;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    d_d         = d_q;
    a_d         = a_q;
    r_d         = r_q;
    q_d         = q_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            d_d     = divisor;
            a_d     = dividend;
            r_d     = '0;
            q_d     = '0;
            count_d = '0;
          end
        end
      end
      RUN: begin
        r_d     = adder_sum;
        q_d     = {q_q[BUS_WIDTH-2:0], ~adder_sum[BUS_WIDTH]};
        a_d     = {a_q[BUS_WIDTH-2:0], 1'b0};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(BUS_WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // A negative partial remainder is pulled back into [0, D).
        r_d         = r_q[BUS_WIDTH] ? adder_sum : r_q;
        quotient_d  = q_q;
        remainder_d = r_d[BUS_WIDTH-1:0];
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      d_q         <= '0;
      a_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      d_q         <= d_d;
      a_q         <= a_d;
      r_q         <= r_d;
      q_q         <= q_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider at BUS_WIDTH=8 and BUS_WIDTH=32.
module tb_nonrestoring_divider;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        busy8, done8, dbz8;

  logic        start32;
  logic [31:0] dividend32, divisor32, quotient32, remainder32;
  logic        busy32, done32, dbz32;

  int total = 0;
  int bad   = 0;

  nonrestoring_divider #(.BUS_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
  );

  nonrestoring_divider #(.BUS_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32),
    .dividend(dividend32), .divisor(divisor32),
    .busy(busy32), .done(done32),
    .quotient(quotient32), .remainder(remainder32), .div_by_zero(dbz32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one 32-bit division, expect done 34 cycles after the start edge.
  task automatic run32(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic [31:0] exp_q, input logic [31:0] exp_r);
    int n;
    start32 = 1'b1; dividend32 = dvd; divisor32 = dvs;
    tick();
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd34);
    check({tag, "_q"}, 64'(quotient32), 64'(exp_q));
    check({tag, "_r"}, 64'(remainder32), 64'(exp_r));
    check({tag, "_dbz"}, 64'(dbz32), 64'd0);
  endtask

  initial begin
    int n;
    int extra_done;
    int busy_low;

    rst_n = 1'b0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    start32 = 1'b0; dividend32 = '0; divisor32 = '0;
    tick();
    tick();
    check("rst8_ctl", {62'd0, busy8, done8}, 64'd0);
    check("rst8_q", 64'(quotient8), 64'd0);
    check("rst8_r", 64'(remainder8), 64'd0);
    check("rst32_ctl", {61'd0, busy32, done32, dbz32}, 64'd0);
    check("rst32_qr", {quotient32, remainder32}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 8-bit: 100/7, busy for 9 cycles, done on the 10th cycle after the start edge
    start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      check("w8_busy_phase", {62'd0, busy8, done8}, 64'b10);
      tick();
    end
    check("w8_done", {62'd0, busy8, done8}, 64'b01);
    check("w8_q", 64'(quotient8), 64'd14);
    check("w8_r", 64'(remainder8), 64'd2);
    check("w8_dbz", 64'(dbz8), 64'd0);
    tick();
    check("w8_idle", {62'd0, busy8, done8}, 64'd0);
    check("w8_hold", {48'd0, quotient8, remainder8}, {48'd0, 8'd14, 8'd2});

    // 32-bit boundary vectors
    run32("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run32("small", 32'd5, 32'd9, 32'd0, 32'd5);
    run32("msb_by_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Divide by zero: done right after the start edge, busy never raised
    start32 = 1'b1; dividend32 = 32'h1234; divisor32 = 32'd0;
    tick();
    start32 = 1'b0;
    check("dz_ctl", {61'd0, busy32, done32, dbz32}, 64'b011);
    check("dz_q", 64'(quotient32), 64'hFFFF_FFFF);
    check("dz_r", 64'(remainder32), 64'h1234);
    tick();
    check("dz_after", {62'd0, busy32, done32}, 64'd0);
    check("dz_hold", 64'(dbz32), 64'd1);

    // Start during RUN is ignored; results held until FIX
    start32 = 1'b1; dividend32 = 32'd1000; divisor32 = 32'd10;
    tick();
    start32 = 1'b0;
    n = 1;
    repeat (5) begin tick(); n++; end
    start32 = 1'b1; dividend32 = 32'd7; divisor32 = 32'd7;
    tick(); n++;
    start32 = 1'b0;
    check("ign_hold_q", 64'(quotient32), 64'hFFFF_FFFF);
    check("ign_hold_r", 64'(remainder32), 64'h1234);
    while (!done32 && n < 60) begin
      tick();
      n++;
    end
    check("ign_lat", 64'(n), 64'd34);
    check("ign_qr", {quotient32, remainder32}, {32'd100, 32'd0});
    check("ign_dbz", 64'(dbz32), 64'd0);
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done32) extra_done++;
    end
    check("ign_single_done", 64'(extra_done), 64'd0);

    // Back-to-back issue in the DONE cycle
    start32 = 1'b1; dividend32 = 32'd1000; divisor32 = 32'd10;
    tick();
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 60) begin
      tick();
      n++;
    end
    check("b2b_first_lat", 64'(n), 64'd34);
    check("b2b_first_qr", {quotient32, remainder32}, {32'd100, 32'd0});
    start32 = 1'b1; dividend32 = 32'd81; divisor32 = 32'd9;
    tick();
    start32 = 1'b0;
    n = 1;
    busy_low = 0;
    while (!done32 && n < 60) begin
      if (!busy32) busy_low++;
      tick();
      n++;
    end
    check("b2b_second_lat", 64'(n), 64'd34);
    check("b2b_busy_low", 64'(busy_low), 64'd0);
    check("b2b_second_qr", {quotient32, remainder32}, {32'd9, 32'd0});
    tick();

    // Reset mid-RUN abandons the division
    start32 = 1'b1; dividend32 = 32'd50; divisor32 = 32'd3;
    tick();
    start32 = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_ctl", {61'd0, busy32, done32, dbz32}, 64'd0);
    check("mid_rst_qr", {quotient32, remainder32}, 64'd0);
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done32 || busy32) extra_done++;
    end
    check("mid_rst_no_done", 64'(extra_done), 64'd0);
    run32("after_rst", 32'd50, 32'd3, 32'd16, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
